gate_tt_checker: RTL and testbench
==================================

# gate_tt_checker

Sequential stimulus/response checker that drives the inputs of a combinational gate under test, samples its output, and compares each sample against an expected truth table. It sits at the driving end of a gate's interface, where the gate consumes its inputs and produces `y`: it walks every input combination, waits for settling, checks `y`, and reports a pass/fail summary. It is used as the on-board self-test companion for the dataflow gate modules.

## Interface
Parameters:
- `N_IN`, 2: number of gate inputs; the checker applies 2^N_IN vectors.
- `SETTLE`, 2: cycles each vector is held before sampling. Must be ≥1.

Ports (`clk` and `rst_n` first):
- `clk` input 1: single clock; everything is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a check run; sampled only in IDLE.
- `exp_tt` input 2^N_IN: expected output; `exp_tt[i]` is the expected `y` when `stim == i`. NAND with N_IN=2 is 4'b0111.
- `y` input 1: output of the gate under test.
- `stim` output N_IN: vector driven to the gate. With N_IN=2, `stim[1]` drives `a` and `stim[0]` drives `b`.
- `busy` output 1: run in progress.
- `done` output 1: one-cycle pulse at the end of a run.
- `pass` output 1: the last run had zero mismatches; held until the next start.
- `err_cnt` output N_IN+1: mismatch count for the last run. Cannot overflow.
- `fail_idx` output N_IN: vector index of the first mismatch. Valid only when `err_cnt != 0`.

## Operation
- Reset values: `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_idx`=0. The FSM is in IDLE.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: on `start`=1 at an edge:
  - `idx` and `stim` go to 0, the settle counter goes to 0, `err_cnt` and `fail_idx` clear, `pass` goes to 0, `busy` goes to 1.
  - Next state is SETTLE.
- SETTLE: the counter increments each cycle. When the counter reaches SETTLE-1, the next state is SAMPLE. `stim` is stable for the whole state.
- SAMPLE (one cycle): compare `y` with `exp_tt[idx]`.
  - On mismatch, `err_cnt` increments.
  - If this is the first mismatch, `fail_idx` captures `idx`.
  - If `idx` = 2^N_IN-1, the next state is DONE.
  - Otherwise `idx`/`stim` increment, the counter clears, and the next state is SETTLE.
- DONE (one cycle): `done`=1, `busy`=0, and `pass` registers (`err_cnt`==0), including any mismatch from the final SAMPLE. Next state is IDLE.
- `start` is ignored in SETTLE, SAMPLE and DONE; no queuing.
- `stim` holds its last value (2^N_IN-1) after a run until the next start.
- Reset asserted mid-run aborts immediately and forces all reset values. `done` does not pulse.

## Timing
- Each vector occupies SETTLE+1 cycles: SETTLE cycles in SETTLE plus 1 in SAMPLE.
- Edge e0 is the edge that samples `start`. `done` is high for exactly one cycle, beginning at edge e0 + 2^N_IN·(SETTLE+1).
  - Example: N_IN=2, SETTLE=2 gives `done` after edge e12.
- `busy` rises at e0 and falls at the same edge `done` rises.
- `stim` changes only on the edge leaving SAMPLE, or on e0.
- `y` is sampled at the end of the SAMPLE cycle.
- `err_cnt`, `fail_idx` and `pass` are stable from the edge that raises `done` until the next accepted start.

## Configuration
- `GATE_CHK_STOP_ON_FAIL_EN`, defined: a mismatch in SAMPLE goes directly to DONE. Consequences:
  - `err_cnt` ends at 1.
  - `fail_idx` equals the failing index.
  - `pass`=0.
  - `done` pulses one cycle after that SAMPLE.
- Not defined: all 2^N_IN vectors are always applied and every mismatch is counted.

## Test plan
All cases use N_IN=2 and SETTLE=2 unless noted.
- **Correct NAND:** `exp_tt`=4'b0111 and `y`=~(stim[1]&stim[0]); pulse `start`.
  - `stim` steps 0,1,2,3, each held 3 cycles.
  - `done` after e12 with `pass`=1, `err_cnt`=0, `busy` high e0–e12.
- **Stuck-at-1 output:** `y`=1, `exp_tt`=4'b0111, macro off → `err_cnt`=1, `fail_idx`=3, `pass`=0, `done` after e12.
- **Stuck-at-0 output:** `y`=0, `exp_tt`=4'b0111.
  - Macro off → `err_cnt`=3, `fail_idx`=0, `pass`=0.
  - Macro on → `done` after e3, `err_cnt`=1, `fail_idx`=0.
- **Start while running:** pulse `start` again at e5 and in the DONE cycle → no restart; second `done` never appears; results unchanged.
- **Reset mid-run:** assert `rst_n`=0 at cycle 7 → all outputs 0 asynchronously, no `done`. After release, a new `start` runs a full 12-cycle check normally.
- **Parameter sweep:** N_IN=3, SETTLE=1, `exp_tt`=8'b01111111 with a correct 3-input NAND → 8 vectors, `done` after e16, `pass`=1.

Source files
------------

// File: rtl/gate_tt_checker_if.sv
// Stimulus/response bundle between gate_tt_checker and the gate under test.
interface gate_tt_checker_if #(
    parameter int N_IN = 2
);
    logic                   start;
    logic [(1<<N_IN)-1:0]   exp_tt;
    logic                   y;
    logic [N_IN-1:0]        stim;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN:0]          err_cnt;
    logic [N_IN-1:0]        fail_idx;

    modport master (
        input  start, exp_tt, y,
        output stim, busy, done, pass, err_cnt, fail_idx
    );

    modport slave (
        output start, exp_tt, y,
        input  stim, busy, done, pass, err_cnt, fail_idx
    );
endinterface

// File: rtl/gate_tt_checker.sv
// Walks every input vector of a combinational gate and checks y against exp_tt.
// Define GATE_CHK_STOP_ON_FAIL_EN to end a run at the first mismatch.
module gate_tt_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    gate_tt_checker_if.master  bus
);
    localparam int NV = 1 << N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t            state, state_n;
    logic [N_IN-1:0]   idx, idx_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [N_IN:0]     err, err_n;
    logic [N_IN-1:0]   fidx, fidx_n;
    logic              busy, busy_n;
    logic              done, done_n;
    logic              pass, pass_n;
    logic              mismatch;
    logic              last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            cnt   <= '0;
            err   <= '0;
            fidx  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            err   <= err_n;
            fidx  <= fidx_n;
            busy  <= busy_n;
            done  <= done_n;
            pass  <= pass_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        cnt_n    = cnt;
        err_n    = err;
        fidx_n   = fidx;
        busy_n   = busy;
        done_n   = 1'b0;
        pass_n   = pass;
        mismatch = (bus.y != bus.exp_tt[idx]);
        last     = (idx == N_IN'(NV - 1));
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        last     = last || mismatch;
`endif
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    idx_n   = '0;
                    cnt_n   = '0;
                    err_n   = '0;
                    fidx_n  = '0;
                    pass_n  = 1'b0;
                    busy_n  = 1'b1;
                    state_n = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == CW'(SETTLE - 1)) state_n = S_SAMPLE;
                else                        cnt_n   = cnt + 1'b1;
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_n = err + 1'b1;
                    if (err == '0) fidx_n = idx;
                end
                // done/busy/pass are registered on entry to DONE so they line up
                // with the edge that leaves the final SAMPLE.
                if (last) begin
                    state_n = S_DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = !mismatch && (err == '0);
                end else begin
                    idx_n   = idx + 1'b1;
                    cnt_n   = '0;
                    state_n = S_SETTLE;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.stim     = idx;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.pass     = pass;
    assign bus.err_cnt  = err;
    assign bus.fail_idx = fidx;
endmodule

// File: tb/tb_gate_tt_checker.sv
// Randomized bench for gate_tt_checker against a truth-table reference model.
module tb_gate_tt_checker;
    logic clk;
    logic rst_n;
    logic [7:0] tt0, tt1, exp0, exp1;
    int n_tests;
    int n_fail;

    gate_tt_checker_if #(.N_IN(2)) bus0 ();
    gate_tt_checker_if #(.N_IN(3)) bus1 ();

    gate_tt_checker #(.N_IN(2), .SETTLE(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    gate_tt_checker #(.N_IN(3), .SETTLE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // The "gate under test" is whatever truth table ttX holds.
    assign bus0.y      = tt0[bus0.stim];
    assign bus1.y      = tt1[bus1.stim];
    assign bus0.exp_tt = exp0[3:0];
    assign bus1.exp_tt = exp1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic get(input int inst, output int stim, output int busy, output int done,
                       output int pass, output int err, output int fidx);
        if (inst == 0) begin
            stim = int'(bus0.stim); busy = int'(bus0.busy); done = int'(bus0.done);
            pass = int'(bus0.pass); err = int'(bus0.err_cnt); fidx = int'(bus0.fail_idx);
        end else begin
            stim = int'(bus1.stim); busy = int'(bus1.busy); done = int'(bus1.done);
            pass = int'(bus1.pass); err = int'(bus1.err_cnt); fidx = int'(bus1.fail_idx);
        end
    endtask

    task automatic set_start(input int inst, input logic v);
        if (inst == 0) bus0.start = v;
        else           bus1.start = v;
    endtask

    task automatic run(input int inst, input logic [7:0] gate, input logic [7:0] expv,
                       input bit poke, input int rst_at);
        int n, s, nv, nvec, total, e_err, e_fidx, ndone;
        int stim, busy, done, pass, err, fidx;
        n = (inst == 0) ? 2 : 3;
        s = (inst == 0) ? 2 : 1;
        nv = 1 << n;
        e_err = 0;
        e_fidx = -1;
        for (int i = 0; i < nv; i++) begin
            if (gate[i] != expv[i]) begin
                e_err++;
                if (e_fidx < 0) e_fidx = i;
            end
        end
        nvec = nv;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        if (e_err > 0) begin
            nvec = e_fidx + 1;
            e_err = 1;
        end
`endif
        total = nvec * (s + 1);

        @(negedge clk);
        if (inst == 0) begin tt0 = gate; exp0 = expv; end
        else           begin tt1 = gate; exp1 = expv; end
        set_start(inst, 1'b1);
        @(posedge clk);
        ndone = 0;
        for (int k = 0; k <= total + 3; k++) begin
            @(negedge clk);
            if (rst_at >= 0 && k == rst_at) begin
                set_start(inst, 1'b0);
                rst_n = 1'b0;
                #1;
                get(inst, stim, busy, done, pass, err, fidx);
                check("rst_stim", stim, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_pass", pass, 0);
                check("rst_err", err, 0);
                check("rst_fidx", fidx, 0);
                repeat (3) begin
                    @(negedge clk);
                    get(inst, stim, busy, done, pass, err, fidx);
                    check("rst_hold_done", done, 0);
                    check("rst_hold_busy", busy, 0);
                end
                rst_n = 1'b1;
                return;
            end
            get(inst, stim, busy, done, pass, err, fidx);
            check("stim", stim, ((k / (s + 1)) < nvec) ? (k / (s + 1)) : nvec - 1);
            check("busy", busy, (k < total) ? 1 : 0);
            check("done", done, (k == total) ? 1 : 0);
            ndone += done;
            set_start(inst, poke && (k == 5 || k == total));
        end
        set_start(inst, 1'b0);
        get(inst, stim, busy, done, pass, err, fidx);
        check("done_count", ndone, 1);
        check("err_cnt", err, e_err);
        check("pass", pass, (e_err == 0) ? 1 : 0);
        if (e_err != 0) check("fail_idx", fidx, e_fidx);
    endtask

    initial begin
        int stim, busy, done, pass, err, fidx;
        logic [7:0] e, g;
        n_tests = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        tt0 = '0; tt1 = '0; exp0 = '0; exp1 = '0;
        repeat (2) @(negedge clk);
        for (int inst = 0; inst < 2; inst++) begin
            get(inst, stim, busy, done, pass, err, fidx);
            check("reset_stim", stim, 0);
            check("reset_busy", busy, 0);
            check("reset_done", done, 0);
            check("reset_pass", pass, 0);
            check("reset_err", err, 0);
            check("reset_fidx", fidx, 0);
        end
        rst_n = 1'b1;

        run(0, 8'h07, 8'h07, 1'b0, -1);
        run(0, 8'h0F, 8'h07, 1'b0, -1);
        run(0, 8'h00, 8'h07, 1'b0, -1);
        run(0, 8'h07, 8'h07, 1'b1, -1);
        run(0, 8'h00, 8'h07, 1'b1, -1);
        run(0, 8'h07, 8'h07, 1'b0, 7);
        run(0, 8'h07, 8'h07, 1'b0, -1);
        run(1, 8'h7F, 8'h7F, 1'b0, -1);

        for (int r = 0; r < 10; r++) begin
            e = 8'($urandom);
            g = ($urandom_range(0, 1) == 1) ? e : 8'($urandom);
            run(r % 2, g, e, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
